// File: rtl/systola_pkg.sv
// Shared definitions for the systolic PE array.
// - pe_state_e : tile accumulation FSM states
// - acc_max/acc_min : largest/smallest accumulator value for a given width
//   and operand signedness, returned right-aligned in MAX_ACC_W bits
package systola_pkg;

  localparam int unsigned MAX_ACC_W = 48;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } pe_state_e;

  // All-ones shifted down to the legal magnitude; signed drops one more bit.
  function automatic logic [MAX_ACC_W-1:0] acc_max(input int unsigned acc_w,
                                                   input bit is_signed);
    logic [MAX_ACC_W-1:0] ones;
    ones = '1;
    if (is_signed) return ones >> (MAX_ACC_W - acc_w + 1);
    return ones >> (MAX_ACC_W - acc_w);
  endfunction

  // Signed minimum is the lone MSB of an acc_w-bit word; unsigned minimum is 0.
  function automatic logic [MAX_ACC_W-1:0] acc_min(input int unsigned acc_w,
                                                   input bit is_signed);
    if (is_signed) return MAX_ACC_W'(1) << (acc_w - 1);
    return '0;
  endfunction

endpackage

// File: rtl/pe_mac_cell_if.sv
// Result channel of a PE MAC cell: valid/ready handshake carrying the
// completed tile sum and its saturation flag.
// - master : result producer (the PE)
// - slave  : result consumer
interface pe_mac_cell_if #(
  parameter int unsigned ACC_W = 24
) ();

  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] res_data;
  logic             res_sat;

  modport master (
    output res_valid,
    output res_data,
    output res_sat,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_data,
    input  res_sat,
    output res_ready
  );

endinterface

// File: rtl/pe_mult.sv
// Stage 1 of the PE pipeline: registered DW x DW multiplier.
// Ports:
//   clk, rstn      clock, async active-low reset
//   fire_i, last_i operand-valid strobe and end-of-tile tag
//   a_i, w_i       activation / weight operands
//   vld_o, last_o  registered valid and last tag of the held product
//   prod_o         registered 2*DW-bit product (two's complement if SIGNED_MODE)
module pe_mult #(
  parameter int unsigned DW          = 8,
  parameter bit          SIGNED_MODE = 1'b0
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            fire_i,
  input  logic            last_i,
  input  logic [DW-1:0]   a_i,
  input  logic [DW-1:0]   w_i,
  output logic            vld_o,
  output logic            last_o,
  output logic [2*DW-1:0] prod_o
);

  logic [2*DW-1:0] prod_c;
  logic [2*DW-1:0] prod_q;
  logic            vld_q;
  logic            last_q;

  // Operands are pre-extended to 2*DW so the truncated product is exact.
  if (SIGNED_MODE) begin : g_signed
    assign prod_c = $signed({{DW{a_i[DW-1]}}, a_i}) * $signed({{DW{w_i[DW-1]}}, w_i});
  end else begin : g_unsigned
    assign prod_c = {{DW{1'b0}}, a_i} * {{DW{1'b0}}, w_i};
  end

  // Product holds when idle; valid and last tag track fire every cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prod_q <= '0;
      vld_q  <= 1'b0;
      last_q <= 1'b0;
    end else begin
      vld_q  <= fire_i;
      last_q <= fire_i & last_i;
      if (fire_i) prod_q <= prod_c;
    end
  end

  assign vld_o  = vld_q;
  assign last_o = last_q;
  assign prod_o = prod_q;

endmodule

// File: rtl/pe_mac_cell.sv
// Systolic-array processing element: forwards operands to neighbours,
// multiplies them (stage 1) and accumulates per tile (stage 2), then hands
// the tile sum out on a valid/ready result channel.
// Ports:
//   clk, rstn            clock, async active-low reset
//   fire, last           operand strobe, end-of-tile tag (qualified by fire)
//   in_a, in_w           operands
//   out_a, out_w         operands forwarded (updated on fire only)
//   out_f, out_l         registered fire and fire&last
//   res                  result channel (res_valid/res_ready/res_data/res_sat)
//   err_overrun          sticky: an unread result was overwritten
//   busy                 tile in progress or product in flight
module pe_mac_cell
  import systola_pkg::*;
#(
  parameter int unsigned DW          = 8,
  parameter int unsigned ACC_W       = 24,
  parameter bit          SIGNED_MODE = 1'b0,
  parameter bit          SAT_EN      = 1'b1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          fire,
  input  logic          last,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_w,
  output logic [DW-1:0] out_a,
  output logic [DW-1:0] out_w,
  output logic          out_f,
  output logic          out_l,
  pe_mac_cell_if.master res,
  output logic          err_overrun,
  output logic          busy
);

  localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(acc_max(ACC_W, SIGNED_MODE));
  localparam logic [ACC_W-1:0] ACC_MIN = ACC_W'(acc_min(ACC_W, SIGNED_MODE));

  // Neighbour forwarding registers
  logic [DW-1:0] out_a_q, out_w_q;
  logic          out_f_q, out_l_q;

  // Stage-1 outputs
  logic            s1_vld;
  logic            s1_last;
  logic [2*DW-1:0] s1_prod;
  logic [ACC_W-1:0] prod_ext;

  // Adder / saturation
  logic [ACC_W:0]   sum_wide;
  logic [ACC_W-1:0] sum_raw;
  logic [ACC_W-1:0] sum_sat;
  logic             ovf_pos;
  logic             ovf_neg;
  logic             ovf_hit;

  // FSM, accumulator and result state
  pe_state_e        state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             tsat_q, tsat_d;
  logic             res_valid_q, res_valid_d;
  logic [ACC_W-1:0] res_data_q, res_data_d;
  logic             res_sat_q, res_sat_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  // Forwarded operands hold between fires; strobes follow every cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_a_q <= '0;
      out_w_q <= '0;
      out_f_q <= 1'b0;
      out_l_q <= 1'b0;
    end else begin
      out_f_q <= fire;
      out_l_q <= fire & last;
      if (fire) begin
        out_a_q <= in_a;
        out_w_q <= in_w;
      end
    end
  end

  pe_mult #(
    .DW          (DW),
    .SIGNED_MODE (SIGNED_MODE)
  ) u_mult (
    .clk    (clk),
    .rstn   (rstn),
    .fire_i (fire),
    .last_i (last),
    .a_i    (in_a),
    .w_i    (in_w),
    .vld_o  (s1_vld),
    .last_o (s1_last),
    .prod_o (s1_prod)
  );

  assign prod_ext = SIGNED_MODE ? ACC_W'($signed(s1_prod)) : ACC_W'(s1_prod);

  // Accumulate with overflow detection in the operand signedness.
  always_comb begin
    sum_wide = {1'b0, acc_q} + {1'b0, prod_ext};
    sum_raw  = sum_wide[ACC_W-1:0];
    ovf_pos  = 1'b0;
    ovf_neg  = 1'b0;
    if (SIGNED_MODE) begin
      ovf_pos = ~acc_q[ACC_W-1] & ~prod_ext[ACC_W-1] &  sum_raw[ACC_W-1];
      ovf_neg =  acc_q[ACC_W-1] &  prod_ext[ACC_W-1] & ~sum_raw[ACC_W-1];
    end else begin
      ovf_pos = sum_wide[ACC_W];
    end
    ovf_hit = SAT_EN & (ovf_pos | ovf_neg);
    if (SAT_EN && ovf_pos)      sum_sat = ACC_MAX;
    else if (SAT_EN && ovf_neg) sum_sat = ACC_MIN;
    else                        sum_sat = sum_raw;
  end

  // FSM next state, accumulator and result channel.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    tsat_d      = tsat_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_sat_d   = res_sat_q;
    err_d       = err_q;

    if (res_valid_q && res.res_ready) res_valid_d = 1'b0;

    case (state_q)
      ST_IDLE:  if (fire) state_d = ST_ACCUM;
      // A new fire on the completion cycle opens the next tile immediately.
      ST_ACCUM: if (s1_vld && s1_last && !fire) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (s1_vld) begin
      if (s1_last) begin
        // Tile done: publish and zero the accumulator for the next tile.
        res_data_d  = sum_sat;
        res_sat_d   = tsat_q | ovf_hit;
        res_valid_d = 1'b1;
        if (res_valid_q && !res.res_ready) err_d = 1'b1;
        acc_d       = '0;
        tsat_d      = 1'b0;
      end else begin
        acc_d  = sum_sat;
        tsat_d = tsat_q | ovf_hit;
      end
    end

    busy_d = (state_d == ST_ACCUM) | fire;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      tsat_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_sat_q   <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      tsat_q      <= tsat_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_sat_q   <= res_sat_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign out_a         = out_a_q;
  assign out_w         = out_w_q;
  assign out_f         = out_f_q;
  assign out_l         = out_l_q;
  assign res.res_valid = res_valid_q;
  assign res.res_data  = res_data_q;
  assign res.res_sat   = res_sat_q;
  assign err_overrun   = err_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_pe_mac_cell.sv
// Bench for pe_mac_cell: four instances share one stimulus stream
//   u_uns : DW=8 ACC_W=24 unsigned, saturating
//   u_sgn : DW=8 ACC_W=24 signed,   saturating
//   u_s16 : DW=8 ACC_W=16 unsigned, saturating
//   u_w16 : DW=8 ACC_W=16 unsigned, wrapping
module tb_pe_mac_cell;

  logic       clk;
  logic       rstn;
  logic       fire;
  logic       last;
  logic [7:0] in_a;
  logic [7:0] in_w;
  logic       res_ready;

  logic [7:0] ua_o, uw_o, sa_o, sw_o, ta_o, tw_o, wa_o, ww_o;
  logic       uf_o, ul_o, sf_o, sl_o, tf_o, tl_o, wf_o, wl_o;
  logic       u_err, s_err, t_err, w_err;
  logic       u_busy, s_busy, t_busy, w_busy;

  pe_mac_cell_if #(.ACC_W(24)) if_uns ();
  pe_mac_cell_if #(.ACC_W(24)) if_sgn ();
  pe_mac_cell_if #(.ACC_W(16)) if_s16 ();
  pe_mac_cell_if #(.ACC_W(16)) if_w16 ();

  assign if_uns.res_ready = res_ready;
  assign if_sgn.res_ready = res_ready;
  assign if_s16.res_ready = res_ready;
  assign if_w16.res_ready = res_ready;

  pe_mac_cell #(.DW(8), .ACC_W(24), .SIGNED_MODE(1'b0), .SAT_EN(1'b1)) u_uns (
    .clk(clk), .rstn(rstn), .fire(fire), .last(last), .in_a(in_a), .in_w(in_w),
    .out_a(ua_o), .out_w(uw_o), .out_f(uf_o), .out_l(ul_o),
    .res(if_uns), .err_overrun(u_err), .busy(u_busy));

  pe_mac_cell #(.DW(8), .ACC_W(24), .SIGNED_MODE(1'b1), .SAT_EN(1'b1)) u_sgn (
    .clk(clk), .rstn(rstn), .fire(fire), .last(last), .in_a(in_a), .in_w(in_w),
    .out_a(sa_o), .out_w(sw_o), .out_f(sf_o), .out_l(sl_o),
    .res(if_sgn), .err_overrun(s_err), .busy(s_busy));

  pe_mac_cell #(.DW(8), .ACC_W(16), .SIGNED_MODE(1'b0), .SAT_EN(1'b1)) u_s16 (
    .clk(clk), .rstn(rstn), .fire(fire), .last(last), .in_a(in_a), .in_w(in_w),
    .out_a(ta_o), .out_w(tw_o), .out_f(tf_o), .out_l(tl_o),
    .res(if_s16), .err_overrun(t_err), .busy(t_busy));

  pe_mac_cell #(.DW(8), .ACC_W(16), .SIGNED_MODE(1'b0), .SAT_EN(1'b0)) u_w16 (
    .clk(clk), .rstn(rstn), .fire(fire), .last(last), .in_a(in_a), .in_w(in_w),
    .out_a(wa_o), .out_w(ww_o), .out_f(wf_o), .out_l(wl_o),
    .res(if_w16), .err_overrun(w_err), .busy(w_busy));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One tile of up to three operand pairs and the expected result per instance.
  typedef struct {
    int              n;
    logic [2:0][7:0] a;
    logic [2:0][7:0] w;
    logic [23:0]     e_uns;
    logic [23:0]     e_sgn;
    logic [15:0]     e_s16;
    logic            e_s16_sat;
    logic [15:0]     e_w16;
  } vec_t;

  function automatic vec_t mk(input int n,
                              input logic [7:0] a0, input logic [7:0] w0,
                              input logic [7:0] a1, input logic [7:0] w1,
                              input logic [7:0] a2, input logic [7:0] w2,
                              input logic [23:0] e_uns, input logic [23:0] e_sgn,
                              input logic [15:0] e_s16, input logic e_s16_sat,
                              input logic [15:0] e_w16);
    vec_t v;
    v.n = n;
    v.a[0] = a0; v.a[1] = a1; v.a[2] = a2;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2;
    v.e_uns = e_uns; v.e_sgn = e_sgn;
    v.e_s16 = e_s16; v.e_s16_sat = e_s16_sat; v.e_w16 = e_w16;
    return v;
  endfunction

  task automatic drive(input logic f, input logic l, input logic [7:0] a, input logic [7:0] w);
    @(negedge clk);
    fire = f; last = l; in_a = a; in_w = w;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " out_a"},    48'(ua_o), 48'd0);
    chk({tag, " out_w"},    48'(uw_o), 48'd0);
    chk({tag, " out_f"},    48'(uf_o), 48'd0);
    chk({tag, " out_l"},    48'(ul_o), 48'd0);
    chk({tag, " res_valid"}, 48'(if_uns.res_valid), 48'd0);
    chk({tag, " res_data"},  48'(if_uns.res_data), 48'd0);
    chk({tag, " res_sat"},   48'(if_uns.res_sat), 48'd0);
    chk({tag, " err"},       48'(u_err), 48'd0);
    chk({tag, " busy"},      48'(u_busy), 48'd0);
  endtask

  vec_t tv[4];

  initial begin
    // 3*4+5*6+2*2 = 46 everywhere (all operands positive as signed too).
    tv[0] = mk(3, 8'd3, 8'd4, 8'd5, 8'd6, 8'd2, 8'd2,
               24'd46, 24'd46, 16'd46, 1'b0, 16'd46);
    // Unsigned 253*4+127*255 = 33397; signed (-3)*4 + 127*(-1) = -139.
    tv[1] = mk(2, 8'd253, 8'd4, 8'd127, 8'd255, 8'd0, 8'd0,
               24'd33397, 24'hFFFF75, 16'd33397, 1'b0, 16'd33397);
    // 3*65025 = 195075: ACC16 clamps to 65535, wraps to 195075-131072 = 64003;
    // signed (-1)*(-1) three times = 3.
    tv[2] = mk(3, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255,
               24'd195075, 24'd3, 16'd65535, 1'b1, 16'd64003);
    // One-product tile straight from IDLE: 200*100 = 20000; signed -56*100 = -5600.
    tv[3] = mk(1, 8'd200, 8'd100, 8'd0, 8'd0, 8'd0, 8'd0,
               24'd20000, 24'hFFEA20, 16'd20000, 1'b0, 16'd20000);

    clk = 1'b0; rstn = 1'b0; fire = 1'b0; last = 1'b0;
    in_a = '0; in_w = '0; res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk); rstn = 1'b1;

    // Table-driven tiles, result consumed immediately.
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < tv[i].n; k++)
        drive(1'b1, k == tv[i].n - 1, tv[i].a[k], tv[i].w[k]);
      @(posedge clk); #1;
      chk($sformatf("v%0d out_l", i), 48'(ul_o), 48'd1);
      chk($sformatf("v%0d out_f", i), 48'(uf_o), 48'd1);
      chk($sformatf("v%0d out_a", i), 48'(ua_o), 48'(tv[i].a[tv[i].n-1]));
      chk($sformatf("v%0d out_w", i), 48'(uw_o), 48'(tv[i].w[tv[i].n-1]));
      chk($sformatf("v%0d busy", i),  48'(u_busy), 48'd1);
      drive(1'b0, 1'b1, 8'hA5, 8'h5A);  // last ignored, operands not forwarded
      @(posedge clk); #1;
      chk($sformatf("v%0d uns valid", i), 48'(if_uns.res_valid), 48'd1);
      chk($sformatf("v%0d uns data", i),  48'(if_uns.res_data), 48'(tv[i].e_uns));
      chk($sformatf("v%0d uns sat", i),   48'(if_uns.res_sat), 48'd0);
      chk($sformatf("v%0d sgn data", i),  48'(if_sgn.res_data), 48'(tv[i].e_sgn));
      chk($sformatf("v%0d s16 data", i),  48'(if_s16.res_data), 48'(tv[i].e_s16));
      chk($sformatf("v%0d s16 sat", i),   48'(if_s16.res_sat), 48'(tv[i].e_s16_sat));
      chk($sformatf("v%0d w16 data", i),  48'(if_w16.res_data), 48'(tv[i].e_w16));
      chk($sformatf("v%0d w16 sat", i),   48'(if_w16.res_sat), 48'd0);
      chk($sformatf("v%0d hold a", i),    48'(ua_o), 48'(tv[i].a[tv[i].n-1]));
      chk($sformatf("v%0d out_f idle", i), 48'(uf_o), 48'd0);
      chk($sformatf("v%0d out_l idle", i), 48'(ul_o), 48'd0);
      chk($sformatf("v%0d busy idle", i), 48'(u_busy), 48'd0);
      @(posedge clk); #1;
      chk($sformatf("v%0d valid drop", i), 48'(if_uns.res_valid), 48'd0);
      fire = 1'b0; last = 1'b0;
    end

    // Back-to-back one-product tiles: (1,1) then (2,3).
    drive(1'b1, 1'b1, 8'd1, 8'd1);
    drive(1'b1, 1'b1, 8'd2, 8'd3);
    @(posedge clk); #1;
    chk("b2b A valid", 48'(if_uns.res_valid), 48'd1);
    chk("b2b A data",  48'(if_uns.res_data), 48'd1);
    drive(1'b0, 1'b0, 8'd0, 8'd0);
    @(posedge clk); #1;
    chk("b2b B valid", 48'(if_uns.res_valid), 48'd1);
    chk("b2b B data",  48'(if_uns.res_data), 48'd6);
    chk("b2b no err",  48'(u_err), 48'd0);
    @(posedge clk); #1;
    chk("b2b drop", 48'(if_uns.res_valid), 48'd0);

    // Overrun: consumer stalled across two completions.
    res_ready = 1'b0;
    drive(1'b1, 1'b1, 8'd2, 8'd2);
    drive(1'b0, 1'b0, 8'd0, 8'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("ovr hold valid", 48'(if_uns.res_valid), 48'd1);
    chk("ovr hold data",  48'(if_uns.res_data), 48'd4);
    chk("ovr no err yet", 48'(u_err), 48'd0);
    drive(1'b1, 1'b1, 8'd3, 8'd3);
    drive(1'b0, 1'b0, 8'd0, 8'd0);
    @(posedge clk); #1;
    chk("ovr new data", 48'(if_uns.res_data), 48'd9);
    chk("ovr err set",  48'(u_err), 48'd1);
    @(negedge clk); res_ready = 1'b1;
    @(posedge clk); #1;
    chk("ovr consumed", 48'(if_uns.res_valid), 48'd0);
    chk("ovr err sticky", 48'(u_err), 48'd1);

    // Reset after two of four fires, then a fresh (7,7) tile.
    drive(1'b1, 1'b0, 8'd5, 8'd5);
    drive(1'b1, 1'b0, 8'd6, 8'd6);
    @(negedge clk);
    fire = 1'b0; rstn = 1'b0;
    #1 chk_all_zero("midrst");
    @(negedge clk); rstn = 1'b1;
    drive(1'b1, 1'b1, 8'd7, 8'd7);
    drive(1'b0, 1'b0, 8'd0, 8'd0);
    @(posedge clk); #1;
    chk("midrst valid", 48'(if_uns.res_valid), 48'd1);
    chk("midrst data",  48'(if_uns.res_data), 48'd49);
    chk("midrst err",   48'(u_err), 48'd0);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
